mm_stream: RTL and testbench
============================

MM_STREAM -- requirements
Module: mm_stream

Interface
REQ-001 The block SHALL have parameter D_W, default 8, meaning the signed A/B element width.
REQ-002 The block SHALL have parameter D_W_ACC, default 32, meaning the signed accumulator and output lane width.
REQ-003 The block SHALL have parameter N2, default 4, meaning the number of parallel MAC lanes, which is also the number of output columns per beat.
REQ-004 The block SHALL have parameter MATRIXSIZE_W, default 24, meaning the width of the dimension inputs.
REQ-005 The block SHALL have parameter MEM_DEPTH_A, default 1024, meaning the A row-buffer depth in elements.
REQ-006 The block SHALL have parameter MEM_DEPTH_B, default 4096, meaning the B store depth in N2-element beats.
REQ-007 The block SHALL have these ports, one per line as name, direction, width, meaning:
- mm_clk, in, 1, the single clock.
- mm_rst_n, in, 1, reset, synchronous and active-low.
- start, in, 1, one-cycle job start; sampled only in IDLE.
- keep_b, in, 1, sampled with start; 1 reuses the stored B and skips LOAD_B.
- M1, M2, M3dN2, in, MATRIXSIZE_W each, the A rows, the inner dimension, and the B column groups.
- s_axis_s2mm_tdata_B, in, D_W*N2, B beat; lane n holds column g*N2+n.
- s_axis_s2mm_tvalid_B, s_axis_s2mm_tlast_B, in, 1 each.
- s_axis_s2mm_tready_B, out, 1.
- s_axis_s2mm_tdata_A, in, D_W, one A element.
- s_axis_s2mm_tvalid_A, s_axis_s2mm_tlast_A, in, 1 each.
- s_axis_s2mm_tready_A, out, 1.
- m_axis_mm2s_tdata, out, D_W_ACC*N2, N2 result lanes.
- m_axis_mm2s_tvalid, m_axis_mm2s_tlast, out, 1 each.
- m_axis_mm2s_tready, in, 1.
- busy, out, 1, high from the cycle after start until the cycle after done.
- done, out, 1, one-cycle pulse when the job completes.
- err, out, 1, sticky error flag; cleared by start or reset.

Function
REQ-008 The block SHALL compute D = A x B, where A is M1xM2, B is M2x(M3dN2*N2), and all arithmetic is signed full-precision D_W x D_W products accumulated in D_W_ACC bits with two's-complement wrap.
REQ-009 The state machine SHALL have the states IDLE, LOAD_B, LOAD_A, MAC, OUT and DONE.
REQ-010 IDLE SHALL go to LOAD_B on start, or to LOAD_A if keep_b=1 and a valid B is held.
REQ-011 LOAD_B SHALL accept M2*M3dN2 beats, written row-major (address = k*M3dN2+g), with tready_B high only in LOAD_B.
REQ-012 LOAD_A SHALL accept M2 elements of one A row into the row buffer, with tready_A high only in LOAD_A.
REQ-013 MAC, per group g, SHALL clear the accumulators, then issue k = 0..M2-1 one per cycle with a 1-cycle memory read and a registered MAC, taking exactly M2+2 cycles.
REQ-014 OUT SHALL hold tvalid with stable tdata until tready; tlast SHALL be 1 on group M3dN2-1 of each row.
REQ-015 After the OUT handshake the block SHALL go to MAC for the next group, else to LOAD_A for the next row, else to DONE after row M1-1.
REQ-016 DONE SHALL last 1 cycle, pulse done, and then return to IDLE.
REQ-017 A transfer SHALL occur only on cycles where tvalid and tready are both high; a stalled input SHALL only freeze the FSM.
REQ-018 A tlast_A that does not coincide exactly with element M2-1 SHALL set err; the row length SHALL always be M2 elements.
REQ-019 A tlast_B that does not coincide exactly with the final B beat SHALL set err.
REQ-020 If M1, M2 or M3dN2 is 0, or M2>MEM_DEPTH_A, or M2*M3dN2>MEM_DEPTH_B at start, the block SHALL set err and go directly to DONE without consuming any beats.
REQ-021 keep_b=1 with no valid B held (after reset, or after an aborted LOAD_B) SHALL be treated as keep_b=0.
REQ-022 A start outside IDLE SHALL be ignored.

Reset
REQ-023 On mm_rst_n=0 at a clock edge the block SHALL enter IDLE.
REQ-024 On reset, all tready, tvalid, tlast, busy, done and err outputs SHALL be 0, m_axis_mm2s_tdata SHALL be 0, and the B-valid flag SHALL be cleared.
REQ-025 Reset mid-job SHALL abandon the job with no further output beats; memory contents need not be cleared.

Configuration
REQ-026 With macro MM_STREAM_BIAS_EN defined, LOAD_B SHALL first accept M3dN2 bias beats (lanes sign-extended to D_W_ACC), followed by the M2*M3dN2 weight beats; accumulators SHALL initialise to the bias of group g; tlast_B is expected on the final weight beat; the MEM_DEPTH_B check SHALL include the bias beats.
REQ-027 Without MM_STREAM_BIAS_EN, no bias store SHALL exist and accumulators SHALL initialise to 0.

Verification
REQ-028 N2=4, M1=1, M2=2, M3dN2=1, A=[1,2], B rows [1,2,3,4] and [5,6,7,8] -> one beat [11,14,17,20], tlast=1, done pulses once.
REQ-029 The same job with m_axis_mm2s_tready held 0 for 10 cycles -> tdata stable throughout and exactly one beat delivered.
REQ-030 A second job with keep_b=1 and A=[-1,0] -> no tready_B asserted and output [-1,-2,-3,-4].
REQ-031 tlast_A asserted on element 0 of M2=2 -> err=1, output still computed over 2 elements, err cleared by the next start.
REQ-032 M2*M3dN2 = MEM_DEPTH_B+1 -> err=1 and done within 2 cycles, with no tready asserted.
REQ-033 With MM_STREAM_BIAS_EN, bias beat [100,0,0,-100] plus the REQ-028 data -> output [111,14,17,-80].

Source files
------------

// File: rtl/mm_stream.sv
// mm_stream: streaming signed matrix multiply D = A x B with N2 parallel MAC lanes.
// B is stored once (row-major beats), A arrives row by row, each row yields M3dN2 output beats.
//
// Ports:
//   mm_clk, mm_rst_n            clock, synchronous active-low reset
//   start, keep_b               job start (IDLE only); keep_b reuses the stored B
//   M1, M2, M3dN2               A rows, inner dimension, B column groups
//   s_axis_s2mm_*_B             B beats, N2 lanes of D_W (LOAD_B only)
//   s_axis_s2mm_*_A             A elements, one D_W element per beat (LOAD_A only)
//   m_axis_mm2s_*               N2 result lanes of D_W_ACC, tlast on last group of a row
//   busy, done, err             job active, completion pulse, sticky error
//
// Optional feature: define MM_STREAM_BIAS_EN to prefix B with M3dN2 bias beats that
// initialise the accumulators of each column group.
module mm_stream #(
  parameter int D_W          = 8,
  parameter int D_W_ACC      = 32,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 24,
  parameter int MEM_DEPTH_A  = 1024,
  parameter int MEM_DEPTH_B  = 4096
) (
  input  logic                     mm_clk,
  input  logic                     mm_rst_n,
  input  logic                     start,
  input  logic                     keep_b,
  input  logic [MATRIXSIZE_W-1:0]  M1,
  input  logic [MATRIXSIZE_W-1:0]  M2,
  input  logic [MATRIXSIZE_W-1:0]  M3dN2,
  input  logic [D_W*N2-1:0]        s_axis_s2mm_tdata_B,
  input  logic                     s_axis_s2mm_tvalid_B,
  input  logic                     s_axis_s2mm_tlast_B,
  output logic                     s_axis_s2mm_tready_B,
  input  logic [D_W-1:0]           s_axis_s2mm_tdata_A,
  input  logic                     s_axis_s2mm_tvalid_A,
  input  logic                     s_axis_s2mm_tlast_A,
  output logic                     s_axis_s2mm_tready_A,
  output logic [D_W_ACC*N2-1:0]    m_axis_mm2s_tdata,
  output logic                     m_axis_mm2s_tvalid,
  output logic                     m_axis_mm2s_tlast,
  input  logic                     m_axis_mm2s_tready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int MW   = MATRIXSIZE_W;
  localparam int CW   = 2 * MW + 1;
  localparam int AA_W = (MEM_DEPTH_A > 1) ? $clog2(MEM_DEPTH_A) : 1;
  localparam int AB_W = (MEM_DEPTH_B > 1) ? $clog2(MEM_DEPTH_B) : 1;
  localparam int P_W  = 2 * D_W;

  localparam logic [MW-1:0]   M_ONE = MW'(1);
  localparam logic [MW:0]     C_ONE = (MW+1)'(1);
  localparam logic [MW:0]     C_TWO = (MW+1)'(2);
  localparam logic [CW-1:0]   W_ONE = CW'(1);
  localparam logic [AA_W-1:0] A_ONE = AA_W'(1);
  localparam logic [AB_W-1:0] B_ONE = AB_W'(1);
  localparam logic [CW-1:0]   DEP_A = CW'(MEM_DEPTH_A);
  localparam logic [CW-1:0]   DEP_B = CW'(MEM_DEPTH_B);

  typedef enum logic [2:0] {
    IDLE, LOAD_B, LOAD_A, MAC, OUT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [MW-1:0]   m1_q, m1_d;
  logic [MW-1:0]   m2_q, m2_d;
  logic [MW-1:0]   m3_q, m3_d;
  logic [CW-1:0]   nb_q, nb_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [AB_W-1:0] wadr_q, wadr_d;
  logic [MW-1:0]   acnt_q, acnt_d;
  logic [MW-1:0]   row_q, row_d;
  logic [MW-1:0]   grp_q, grp_d;
  logic [MW:0]     cyc_q, cyc_d;
  logic [AA_W-1:0] ard_q, ard_d;
  logic [AB_W-1:0] brd_q, brd_d;
  logic            bval_q, bval_d;
  logic            err_q, err_d;

  logic [N2-1:0][D_W_ACC-1:0] acc_q, acc_d;

  logic [D_W-1:0]    amem [MEM_DEPTH_A];
  logic [D_W*N2-1:0] bmem [MEM_DEPTH_B];
  logic [D_W-1:0]    a_rd_q;
  logic [D_W*N2-1:0] b_rd_q;

  logic [CW-1:0] nb_w;
  logic [CW-1:0] nb_need;
  logic          bad_dims;
  logic          b_final;
  logic          b_wbeat;
  logic          a_last;
  logic          g_last;
  logic [MW:0]   m2_c;
  logic          rd_en;
  logic          a_we;
  logic          w_we;

  logic signed [P_W-1:0] prod;

  assign nb_w = CW'(M2) * CW'(M3dN2);

`ifdef MM_STREAM_BIAS_EN
  logic [D_W*N2-1:0] bias_mem [MEM_DEPTH_B];
  logic [D_W*N2-1:0] bias_rd;
  logic              bias_we;

  // Bias beats come first, so the total includes one extra beat per group.
  assign nb_need = nb_w + CW'(M3dN2);
  assign b_wbeat = (bcnt_q >= CW'(m3_q));
  assign bias_we = (state_q == LOAD_B) && s_axis_s2mm_tvalid_B && !b_wbeat;
  assign bias_rd = bias_mem[AB_W'(grp_q)];

  always_ff @(posedge mm_clk) begin
    if (bias_we) bias_mem[AB_W'(bcnt_q)] <= s_axis_s2mm_tdata_B;
  end
`else
  assign nb_need = nb_w;
  assign b_wbeat = 1'b1;
`endif

  assign bad_dims = (M1 == '0) || (M2 == '0) || (M3dN2 == '0) ||
                    (CW'(M2) > DEP_A) || (nb_need > DEP_B);

  assign b_final = (bcnt_q == nb_q - W_ONE);
  assign a_last  = (acnt_q == m2_q - M_ONE);
  assign g_last  = (grp_q == m3_q - M_ONE);
  assign m2_c    = (MW+1)'(m2_q);

  // Cycle 0 clears, cycles 1..M2 read k=cyc-1, cycles 2..M2+1 accumulate.
  assign rd_en = (state_q == MAC) && (cyc_q != '0) && (cyc_q <= m2_c);
  assign a_we  = (state_q == LOAD_A) && s_axis_s2mm_tvalid_A;
  assign w_we  = (state_q == LOAD_B) && s_axis_s2mm_tvalid_B && b_wbeat;

  always_ff @(posedge mm_clk) begin
    if (a_we) amem[AA_W'(acnt_q)] <= s_axis_s2mm_tdata_A;
    if (w_we) bmem[wadr_q] <= s_axis_s2mm_tdata_B;
    if (rd_en) begin
      a_rd_q <= amem[ard_q];
      b_rd_q <= bmem[brd_q];
    end
  end

  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    m3_d    = m3_q;
    nb_d    = nb_q;
    bcnt_d  = bcnt_q;
    wadr_d  = wadr_q;
    acnt_d  = acnt_q;
    row_d   = row_q;
    grp_d   = grp_q;
    cyc_d   = cyc_q;
    ard_d   = ard_q;
    brd_d   = brd_q;
    bval_d  = bval_q;
    err_d   = err_q;
    acc_d   = acc_q;
    prod    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m1_d   = M1;
          m2_d   = M2;
          m3_d   = M3dN2;
          nb_d   = nb_need;
          err_d  = 1'b0;
          bcnt_d = '0;
          wadr_d = '0;
          acnt_d = '0;
          row_d  = '0;
          grp_d  = '0;
          cyc_d  = '0;
          if (bad_dims) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (keep_b && bval_q) begin
            state_d = LOAD_A;
          end else begin
            // B store is overwritten from here on, so it is no longer valid.
            bval_d  = 1'b0;
            state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (s_axis_s2mm_tvalid_B) begin
          bcnt_d = bcnt_q + W_ONE;
          if (b_wbeat) wadr_d = wadr_q + B_ONE;
          if (s_axis_s2mm_tlast_B != b_final) err_d = 1'b1;
          if (b_final) begin
            bval_d  = 1'b1;
            acnt_d  = '0;
            state_d = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (s_axis_s2mm_tvalid_A) begin
          acnt_d = acnt_q + M_ONE;
          if (s_axis_s2mm_tlast_A != a_last) err_d = 1'b1;
          if (a_last) begin
            acnt_d  = '0;
            grp_d   = '0;
            cyc_d   = '0;
            state_d = MAC;
          end
        end
      end
      MAC: begin
        cyc_d = cyc_q + C_ONE;
        if (cyc_q == '0) begin
          ard_d = '0;
          brd_d = AB_W'(grp_q);
          for (int n = 0; n < N2; n++) begin
`ifdef MM_STREAM_BIAS_EN
            acc_d[n] = D_W_ACC'($signed(bias_rd[n*D_W +: D_W]));
`else
            acc_d[n] = '0;
`endif
          end
        end
        if (rd_en) begin
          ard_d = ard_q + A_ONE;
          brd_d = brd_q + AB_W'(m3_q);
        end
        if (cyc_q >= C_TWO) begin
          for (int n = 0; n < N2; n++) begin
            prod = P_W'($signed(a_rd_q)) *
                   P_W'($signed(b_rd_q[n*D_W +: D_W]));
            acc_d[n] = acc_q[n] + D_W_ACC'(prod);
          end
        end
        if (cyc_q == m2_c + C_ONE) state_d = OUT;
      end
      OUT: begin
        if (m_axis_mm2s_tready) begin
          cyc_d = '0;
          if (g_last) begin
            grp_d = '0;
            if (row_q == m1_q - M_ONE) begin
              state_d = DONE;
            end else begin
              row_d   = row_q + M_ONE;
              acnt_d  = '0;
              state_d = LOAD_A;
            end
          end else begin
            grp_d   = grp_q + M_ONE;
            state_d = MAC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      state_q <= IDLE;
      m1_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      nb_q    <= '0;
      bcnt_q  <= '0;
      wadr_q  <= '0;
      acnt_q  <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      cyc_q   <= '0;
      ard_q   <= '0;
      brd_q   <= '0;
      bval_q  <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      nb_q    <= nb_d;
      bcnt_q  <= bcnt_d;
      wadr_q  <= wadr_d;
      acnt_q  <= acnt_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
      cyc_q   <= cyc_d;
      ard_q   <= ard_d;
      brd_q   <= brd_d;
      bval_q  <= bval_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign s_axis_s2mm_tready_B = (state_q == LOAD_B);
  assign s_axis_s2mm_tready_A = (state_q == LOAD_A);
  assign m_axis_mm2s_tvalid   = (state_q == OUT);
  assign m_axis_mm2s_tlast    = (state_q == OUT) && g_last;
  assign m_axis_mm2s_tdata    = acc_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign err                  = err_q;

endmodule

// File: tb/tb_mm_stream.sv
// tb_mm_stream: randomized self-checking bench for mm_stream.
// Expected beats come from a plain sum-of-products model over the bench's A/B arrays.
module tb_mm_stream;

  localparam int DW  = 8;
  localparam int DWA = 32;
  localparam int NL  = 4;
  localparam int MW  = 24;
  localparam int OW  = DWA * NL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          keep_b;
  logic [MW-1:0] m1_s, m2_s, m3_s;
  logic [DW*NL-1:0] b_data;
  logic          b_valid, b_last, b_ready;
  logic [DW-1:0] a_data;
  logic          a_valid, a_last, a_ready;
  logic [OW-1:0] o_data;
  logic          o_valid, o_last, o_ready;
  logic          busy, done, err;

  mm_stream dut (
    .mm_clk               (clk),
    .mm_rst_n             (rst_n),
    .start                (start),
    .keep_b               (keep_b),
    .M1                   (m1_s),
    .M2                   (m2_s),
    .M3dN2                (m3_s),
    .s_axis_s2mm_tdata_B  (b_data),
    .s_axis_s2mm_tvalid_B (b_valid),
    .s_axis_s2mm_tlast_B  (b_last),
    .s_axis_s2mm_tready_B (b_ready),
    .s_axis_s2mm_tdata_A  (a_data),
    .s_axis_s2mm_tvalid_A (a_valid),
    .s_axis_s2mm_tlast_A  (a_last),
    .s_axis_s2mm_tready_A (a_ready),
    .m_axis_mm2s_tdata    (o_data),
    .m_axis_mm2s_tvalid   (o_valid),
    .m_axis_mm2s_tlast    (o_last),
    .m_axis_mm2s_tready   (o_ready),
    .busy                 (busy),
    .done                 (done),
    .err                  (err)
  );

  int checks = 0;
  int failures = 0;

  int A  [0:7][0:15];
  int B  [0:15][0:31];
  int BI [0:31];
  bit b_held = 1'b0;
  int held_m2 = 0;
  int held_m3 = 0;

  logic [OW-1:0] got_d[$];
  logic          got_l[$];
  bit tmo;
  int ndone;
  bit saw_rb;
  int unstable;
  int extra_v;

  function automatic logic [OW-1:0] pack4(int l0, int l1, int l2, int l3);
    logic [OW-1:0] e;
    e[31:0]   = l0;
    e[63:32]  = l1;
    e[95:64]  = l2;
    e[127:96] = l3;
    return e;
  endfunction

  function automatic logic [OW-1:0] exp_beat(int r, int g, int m2);
    logic [OW-1:0] e;
    int s;
    e = '0;
    for (int n = 0; n < NL; n++) begin
      s = 0;
`ifdef MM_STREAM_BIAS_EN
      s = BI[g*NL+n];
`endif
      for (int k = 0; k < m2; k++) s += A[r][k] * B[k][g*NL+n];
      e[n*DWA +: DWA] = s;
    end
    return e;
  endfunction

  function automatic logic [DW*NL-1:0] beat_b(int i, int m3);
    logic [DW*NL-1:0] v;
    int j, k, g;
    v = '0;
    j = i;
`ifdef MM_STREAM_BIAS_EN
    if (i < m3) begin
      for (int n = 0; n < NL; n++) v[n*DW +: DW] = 8'(BI[i*NL+n]);
      return v;
    end
    j = i - m3;
`endif
    k = j / m3;
    g = j % m3;
    for (int n = 0; n < NL; n++) v[n*DW +: DW] = 8'(B[k][g*NL+n]);
    return v;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic feed_b(input int m2, input int m3, input bit rnd);
    int tot, i, guard;
    bit hs;
    tot = m2 * m3;
`ifdef MM_STREAM_BIAS_EN
    tot = tot + m3;
`endif
    i = 0;
    guard = 0;
    while (i < tot && !tmo) begin
      b_data  = beat_b(i, m3);
      b_last  = (i == tot - 1);
      b_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      hs = b_valid && b_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
      if (guard > 6000) tmo = 1'b1;
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  task automatic feed_a(input int m1, input int m2, input int bad, input bit rnd);
    int i, r, k, guard;
    bit hs;
    i = 0;
    guard = 0;
    while (i < m1 * m2 && !tmo) begin
      r = i / m2;
      k = i % m2;
      a_data  = 8'(A[r][k]);
      if (bad >= 0 && r == 0) a_last = (k == bad);
      else a_last = (k == m2 - 1);
      a_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      hs = a_valid && a_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
      if (guard > 6000) tmo = 1'b1;
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic collect(input int hold, input bit rnd);
    int cyc, hl;
    bit prev_hold;
    logic [OW-1:0] held;
    cyc = 0;
    hl = hold;
    prev_hold = 1'b0;
    held = '0;
    while (ndone == 0 && !tmo) begin
      o_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      if (hl > 0) o_ready = 1'b0;
      @(negedge clk);
      if (b_ready) saw_rb = 1'b1;
      if (o_valid) begin
        if (prev_hold && o_data !== held) unstable++;
        if (o_ready) begin
          got_d.push_back(o_data);
          got_l.push_back(o_last);
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          held = o_data;
          if (hl > 0) hl--;
        end
      end
      if (done) ndone++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 8000) tmo = 1'b1;
    end
    o_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
      if (o_valid) extra_v++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_job(input int m1, input int m2, input int m3, input bit keep,
                         input int bad, input bit rnd, input int hold);
    bit need_b;
    got_d.delete();
    got_l.delete();
    tmo = 1'b0;
    ndone = 0;
    saw_rb = 1'b0;
    unstable = 0;
    extra_v = 0;
    m1_s = MW'(m1);
    m2_s = MW'(m2);
    m3_s = MW'(m3);
    keep_b = keep;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    keep_b = 1'b0;
    need_b = !(keep && b_held);
    fork
      begin if (need_b) feed_b(m2, m3, rnd); end
      feed_a(m1, m2, bad, rnd);
      collect(hold, rnd);
    join
    if (need_b) begin
      b_held = 1'b1;
      held_m2 = m2;
      held_m3 = m3;
    end
  endtask

  task automatic set_basic_data();
    for (int n = 0; n < NL; n++) begin
      B[0][n] = n + 1;
      B[1][n] = n + 5;
      BI[n] = 0;
    end
    A[0][0] = 1;
    A[0][1] = 2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    keep_b = 1'b0;
    m1_s = '0; m2_s = '0; m3_s = '0;
    b_data = '0; b_valid = 1'b0; b_last = 1'b0;
    a_data = '0; a_valid = 1'b0; a_last = 1'b0;
    o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_ready, a_ready, o_valid, o_last, busy, done, err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000000",
               {b_ready, a_ready, o_valid, o_last, busy, done, err});
    end
    checks++;
    if (o_data !== '0) begin
      failures++;
      $display("FAIL reset_tdata got=%h exp=0", o_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [OW-1:0] e;
    set_basic_data();
    run_job(1, 2, 1, 1'b0, -1, 1'b0, 0);
    e = pack4(11, 14, 17, 20);
    checks++;
    if (tmo || got_d.size() != 1 || extra_v != 0) begin
      failures++;
      $display("FAIL basic_beats got=%0d tmo=%0d extra=%0d exp=1", got_d.size(), tmo, extra_v);
    end else begin
      checks++;
      if (got_d[0] !== e) begin
        failures++;
        $display("FAIL basic_data got=%h exp=%h", got_d[0], e);
      end
      checks++;
      if (got_l[0] !== 1'b1) begin
        failures++;
        $display("FAIL basic_tlast got=%b exp=1", got_l[0]);
      end
    end
    checks++;
    if (ndone != 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got=%0d err=%b exp=1 err=0", ndone, err);
    end
  endtask

  task automatic test_stall();
    run_job(1, 2, 1, 1'b0, -1, 1'b0, 10);
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL stall_stable got=%0d exp=0", unstable);
    end
    checks++;
    if (tmo || got_d.size() != 1 || extra_v != 0) begin
      failures++;
      $display("FAIL stall_beats got=%0d extra=%0d exp=1", got_d.size(), extra_v);
    end else begin
      checks++;
      if (got_d[0] !== pack4(11, 14, 17, 20)) begin
        failures++;
        $display("FAIL stall_data got=%h exp=%h", got_d[0], pack4(11, 14, 17, 20));
      end
    end
  endtask

  task automatic test_keep_b();
    A[0][0] = -1;
    A[0][1] = 0;
    run_job(1, 2, 1, 1'b1, -1, 1'b0, 0);
    checks++;
    if (saw_rb) begin
      failures++;
      $display("FAIL keep_tready_b got=1 exp=0");
    end
    checks++;
    if (tmo || got_d.size() != 1 || got_d[0] !== pack4(-1, -2, -3, -4)) begin
      failures++;
      $display("FAIL keep_data got=%h n=%0d exp=%h",
               (got_d.size() > 0) ? got_d[0] : '0, got_d.size(), pack4(-1, -2, -3, -4));
    end
  endtask

  task automatic test_tlast_a();
    A[0][0] = 1;
    A[0][1] = 2;
    run_job(1, 2, 1, 1'b1, 0, 1'b0, 0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL tlast_a_err got=%b exp=1", err);
    end
    checks++;
    if (tmo || got_d.size() != 1 || got_d[0] !== pack4(11, 14, 17, 20)) begin
      failures++;
      $display("FAIL tlast_a_data n=%0d exp=%h", got_d.size(), pack4(11, 14, 17, 20));
    end
    A[0][0] = 2;
    A[0][1] = 1;
    run_job(1, 2, 1, 1'b1, -1, 1'b0, 0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL tlast_a_clear got=%b exp=0", err);
    end
    checks++;
    if (tmo || got_d.size() != 1 || got_d[0] !== pack4(7, 10, 13, 16)) begin
      failures++;
      $display("FAIL tlast_a_next n=%0d exp=%h", got_d.size(), pack4(7, 10, 13, 16));
    end
  endtask

`ifdef MM_STREAM_BIAS_EN
  task automatic test_bias();
    set_basic_data();
    BI[0] = 100;
    BI[3] = -100;
    run_job(1, 2, 1, 1'b0, -1, 1'b0, 0);
    checks++;
    if (tmo || got_d.size() != 1 || got_d[0] !== pack4(111, 14, 17, -80)) begin
      failures++;
      $display("FAIL bias_data n=%0d got=%h exp=%h", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : '0, pack4(111, 14, 17, -80));
    end
  endtask
`endif

  task automatic test_random();
    int m1, m2, m3, nb;
    bit keep;
    logic [OW-1:0] e;
    for (int it = 0; it < 8; it++) begin
      keep = b_held && ($urandom_range(2) == 0);
      m1 = int'($urandom_range(1, 3));
      if (keep) begin
        m2 = held_m2;
        m3 = held_m3;
      end else begin
        m2 = int'($urandom_range(1, 6));
        m3 = int'($urandom_range(1, 3));
        for (int k = 0; k < m2; k++)
          for (int c = 0; c < m3 * NL; c++) B[k][c] = rnd8();
        for (int c = 0; c < m3 * NL; c++) BI[c] = rnd8();
      end
      for (int r = 0; r < m1; r++)
        for (int k = 0; k < m2; k++) A[r][k] = rnd8();
      run_job(m1, m2, m3, keep, -1, 1'b1, 0);
      nb = m1 * m3;
      checks++;
      if (tmo || got_d.size() != nb || ndone != 1 || err !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_count got=%0d tmo=%0d done=%0d err=%b exp=%0d",
                 it, got_d.size(), tmo, ndone, err, nb);
      end else begin
        for (int b = 0; b < nb; b++) begin
          e = exp_beat(b / m3, b % m3, m2);
          checks++;
          if (got_d[b] !== e || got_l[b] !== ((b % m3) == m3 - 1)) begin
            failures++;
            $display("FAIL rnd%0d_beat%0d got=%h last=%b exp=%h", it, b, got_d[b], got_l[b], e);
          end
        end
      end
    end
  endtask

  task automatic test_bad_dims();
    int seen;
    bit rdy;
    for (int t = 0; t < 2; t++) begin
      m1_s = (t == 0) ? MW'(1) : MW'(0);
      m2_s = (t == 0) ? MW'(17) : MW'(2);
      m3_s = (t == 0) ? MW'(241) : MW'(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        if (a_ready || b_ready) rdy = 1'b1;
        if (done && seen == 0) seen = i + 1;
        @(posedge clk); #1;
      end
      checks++;
      if (seen == 0 || rdy) begin
        failures++;
        $display("FAIL bad_dims%0d_done seen=%0d ready=%b exp=done,no ready", t, seen, rdy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL bad_dims%0d_err got err=%b busy=%b done=%b exp=1,0,0", t, err, busy, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int bad_v;
    m1_s = MW'(1);
    m2_s = MW'(3);
    m3_s = MW'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b_valid = 1'b1;
    b_data = 32'h0102_0304;
    repeat (3) @(posedge clk);
    #1;
    b_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({b_ready, a_ready, o_valid, busy, done, err} !== 6'b0 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_out got=%b data=%h exp=0",
               {b_ready, a_ready, o_valid, busy, done, err}, o_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_held = 1'b0;
    bad_v = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid || busy) bad_v++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_v != 0) begin
      failures++;
      $display("FAIL reset_mid_idle got=%0d exp=0", bad_v);
    end
    for (int k = 0; k < 2; k++) begin
      A[0][k] = rnd8();
      for (int n = 0; n < NL; n++) B[k][n] = rnd8();
    end
    for (int n = 0; n < NL; n++) BI[n] = rnd8();
    run_job(1, 2, 1, 1'b1, -1, 1'b0, 0);
    checks++;
    if (!saw_rb) begin
      failures++;
      $display("FAIL reset_mid_keep got=no tready_B exp=LOAD_B");
    end
    checks++;
    if (tmo || got_d.size() != 1 || got_d[0] !== exp_beat(0, 0, 2)) begin
      failures++;
      $display("FAIL reset_mid_data n=%0d exp=%h", got_d.size(), exp_beat(0, 0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_keep_b();
    test_tlast_a();
`ifdef MM_STREAM_BIAS_EN
    test_bias();
`endif
    test_random();
    test_bad_dims();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
